// File: rtl/melody_sequencer.sv
// Multi-voice square-wave melody player stepping through a synchronous note ROM.
// Optional per-note decay envelope is enabled with `define MELODY_ENVELOPE_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | silent, waits for start; rom_addr parked at 0
// FETCH    | note address presented to the ROM, outputs hold
// WAIT_ROM | ROM word latched into half-period registers, tones reset
// PLAY     | tones run; beat counter paces the note, then next note/end
module melody_sequencer #(
  parameter int NUM_VOICES  = 2,
  parameter int PERIOD_W    = 19,
  parameter int ADDR_W      = 10,
  parameter int SONG_LEN    = 1000,
  parameter int BEAT_CYCLES = 2500000,
  parameter int AMPLITUDE   = 100000000,
  parameter int SAMPLE_W    = 32
) (
  input  logic                             CLOCK_50,
  input  logic                             resetn,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             loop_en,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [NUM_VOICES*PERIOD_W-1:0]   rom_data,
  output logic signed [SAMPLE_W-1:0]       sample_out,
  output logic                             playing,
  output logic                             done
);

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic signed [SAMPLE_W+1:0] AMP     = (SAMPLE_W+2)'(AMPLITUDE);
  localparam logic signed [SAMPLE_W+1:0] SAT_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W+1:0] SAT_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_ROM, S_PLAY} state_t;

  state_t                    state, state_nx;
  logic [ADDR_W-1:0]         addr_nx;
  logic                      done_nx;
  logic [BEAT_W-1:0]         beat_cnt;
  logic                      last_beat, last_note;
  logic [PERIOD_W-1:0]       half_p   [NUM_VOICES];
  logic [PERIOD_W-1:0]       tone_cnt [NUM_VOICES];
  logic [NUM_VOICES-1:0]     level;
  logic signed [SAMPLE_W+1:0] amp_eff, mix_sum;
  logic signed [SAMPLE_W-1:0] sample_nx;

  assign last_beat = (beat_cnt == BEAT_W'(BEAT_CYCLES-1));
  assign last_note = (rom_addr == ADDR_W'(SONG_LEN-1));
  assign playing   = (state != S_IDLE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      rom_addr <= addr_nx;
      done     <= done_nx;
    end
  end

  // stop overrides everything, including a simultaneous start
  always_comb begin
    state_nx = state;
    addr_nx  = rom_addr;
    done_nx  = 1'b0;
    if (stop) begin
      state_nx = S_IDLE;
      addr_nx  = '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state_nx = S_FETCH;
          addr_nx  = '0;
        end
        S_FETCH:    state_nx = S_WAIT_ROM;
        S_WAIT_ROM: state_nx = S_PLAY;
        S_PLAY: if (last_beat) begin
          if (!last_note) begin
            state_nx = S_FETCH;
            addr_nx  = rom_addr + ADDR_W'(1);
          end else if (loop_en) begin
            state_nx = S_FETCH;
            addr_nx  = '0;
          end else begin
            state_nx = S_IDLE;
            addr_nx  = '0;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)
      beat_cnt <= '0;
    else if (state == S_PLAY)
      beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
    else
      beat_cnt <= '0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        half_p[v]   <= '0;
        tone_cnt[v] <= '0;
      end
    end else if (state == S_WAIT_ROM) begin
      level <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        half_p[v]   <= rom_data[v*PERIOD_W +: PERIOD_W];
        tone_cnt[v] <= '0;
      end
    end else if (state == S_PLAY) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (half_p[v] == '0) begin
          tone_cnt[v] <= '0;
        end else if (tone_cnt[v] == half_p[v] - PERIOD_W'(1)) begin
          tone_cnt[v] <= '0;
          level[v]    <= ~level[v];
        end else begin
          tone_cnt[v] <= tone_cnt[v] + PERIOD_W'(1);
        end
      end
    end
  end

`ifdef MELODY_ENVELOPE_EN
  // decay step k = floor(4*beat_cnt/BEAT_CYCLES), compared without a divider
  localparam logic [BEAT_W+1:0] Q1 = (BEAT_W+2)'(BEAT_CYCLES);
  localparam logic [BEAT_W+1:0] Q2 = (BEAT_W+2)'(2*BEAT_CYCLES);
  localparam logic [BEAT_W+1:0] Q3 = (BEAT_W+2)'(3*BEAT_CYCLES);
  logic [BEAT_W+1:0] beat_x4;
  logic [1:0]        env_k;

  always_comb begin
    beat_x4 = {beat_cnt, 2'b00};
    env_k   = 2'd0;
    if (state == S_PLAY) begin
      if (beat_x4 >= Q3)      env_k = 2'd3;
      else if (beat_x4 >= Q2) env_k = 2'd2;
      else if (beat_x4 >= Q1) env_k = 2'd1;
    end
    amp_eff = AMP >>> env_k;
  end
`else
  assign amp_eff = AMP;
`endif

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (half_p[v] != '0)
        mix_sum = level[v] ? mix_sum + amp_eff : mix_sum - amp_eff;
    end
    if (mix_sum > SAT_MAX)
      sample_nx = SAT_MAX[SAMPLE_W-1:0];
    else if (mix_sum < SAT_MIN)
      sample_nx = SAT_MIN[SAMPLE_W-1:0];
    else
      sample_nx = mix_sum[SAMPLE_W-1:0];
  end

  // silent whenever IDLE or about to enter it; held across FETCH/WAIT_ROM
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)
      sample_out <= '0;
    else if (state == S_IDLE || state_nx == S_IDLE)
      sample_out <= '0;
    else if (state == S_PLAY)
      sample_out <= sample_nx;
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a note-table model pushes expected
// per-cycle outputs; a negedge monitor pops and compares while the DUT is active.
module tb_melody_sequencer;

  localparam int AMP     = 1000;
  localparam int AMP_SAT = 20000;
  localparam int BEAT    = 8;

  logic              CLOCK_50 = 1'b0;
  logic              resetn   = 1'b0;
  logic              start    = 1'b0;
  logic              stop     = 1'b0;
  logic              loop_en  = 1'b0;
  logic [1:0]        rom_addr, rom_addr_s;
  logic [7:0]        rom_data   = '0;
  logic [7:0]        rom_data_s = '0;
  logic signed [15:0] sample_out, sample_out_s;
  logic              playing, playing_s, done, done_s;

  logic [7:0] rom_mem [4];
  int p0_tab [4] = '{2, 3, 0, 1};
  int p1_tab [4] = '{0, 3, 0, 2};

  typedef struct { int addr; int smp; int smp_s; int play; int dn; } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  melody_sequencer #(.NUM_VOICES(2), .PERIOD_W(4), .ADDR_W(2), .SONG_LEN(4),
    .BEAT_CYCLES(BEAT), .AMPLITUDE(AMP), .SAMPLE_W(16)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop),
    .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample_out(sample_out), .playing(playing), .done(done));

  melody_sequencer #(.NUM_VOICES(2), .PERIOD_W(4), .ADDR_W(2), .SONG_LEN(4),
    .BEAT_CYCLES(BEAT), .AMPLITUDE(AMP_SAT), .SAMPLE_W(16)) dut_sat (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop),
    .loop_en(loop_en), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .sample_out(sample_out_s), .playing(playing_s), .done(done_s));

  initial begin
    rom_mem[0] = {4'd0, 4'd2};
    rom_mem[1] = {4'd3, 4'd3};
    rom_mem[2] = {4'd0, 4'd0};
    rom_mem[3] = {4'd2, 4'd1};
  end

  always @(posedge CLOCK_50) begin
    rom_data   <= rom_mem[rom_addr];
    rom_data_s <= rom_mem[rom_addr_s];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int contrib(input int p, input int j, input int amp);
    int a;
    if (p == 0) return 0;
    a = amp;
`ifdef MELODY_ENVELOPE_EN
    a = amp >> ((4 * j) / BEAT);
`endif
    return ((j / p) % 2) ? a : -a;
  endfunction

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int mix(input int note, input int j, input int amp);
    return sat16(contrib(p0_tab[note], j, amp) + contrib(p1_tab[note], j, amp));
  endfunction

  // c counts cycles from FETCH entry: 10 cycles per note (FETCH, WAIT_ROM, 8x PLAY).
  // Sample at PLAY beat i>=1 reflects levels of beat i-1; beat 7 shows in next FETCH.
  task automatic push_trace(input int ncyc, input bit fin);
    exp_t e;
    int note, ph, prv, prv_s;
    prv = 0;
    prv_s = 0;
    for (int c = 0; c < ncyc; c++) begin
      note = (c / 10) % 4;
      ph   = c % 10;
      if (ph == 0 && c >= 10) begin
        prv   = mix((note + 3) % 4, 7, AMP);
        prv_s = mix((note + 3) % 4, 7, AMP_SAT);
      end else if (ph >= 3) begin
        prv   = mix(note, ph - 3, AMP);
        prv_s = mix(note, ph - 3, AMP_SAT);
      end
      e.addr = note; e.smp = prv; e.smp_s = prv_s; e.play = 1; e.dn = 0;
      sb_q.push_back(e);
    end
    if (fin) begin
      e.addr = 0; e.smp = 0; e.smp_s = 0; e.play = 0; e.dn = 1;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge CLOCK_50) begin
    exp_t e;
    if (resetn && (playing || done)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rom_addr", int'(rom_addr), e.addr);
        chk("sample_out", int'(sample_out), e.smp);
        chk("sample_sat", int'(sample_out_s), e.smp_s);
        chk("playing", int'(playing), e.play);
        chk("done", int'(done), e.dn);
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 80) begin
      @(posedge CLOCK_50);
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"}, int'(rom_addr), 0);
    chk({tag, "_sample"}, int'(sample_out), 0);
    chk({tag, "_sample_sat"}, int'(sample_out_s), 0);
    chk({tag, "_playing"}, int'(playing), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #3 chk_idle("reset");
    @(posedge CLOCK_50) #2 resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);

    // full non-looping song with a start pulse
    @(posedge CLOCK_50) #2;
    push_trace(40, 1'b1);
    start = 1'b1;
    @(posedge CLOCK_50) #2 start = 1'b0;
    drain("song_drain");
    repeat (3) @(posedge CLOCK_50);
    #3 chk_idle("after_song");

    // loop_en high only around song end: wrap 3->0, then stop mid note 1
    @(posedge CLOCK_50) #2;
    push_trace(56, 1'b0);
    start = 1'b1;
    for (int c = 0; c < 56; c++) begin
      @(posedge CLOCK_50) #2;
      start   = 1'b0;
      loop_en = (c >= 30 && c <= 42);
      stop    = (c == 55);
    end
    @(posedge CLOCK_50) #2 stop = 1'b0;
    #1 chk_idle("after_stop");
    chk("loop_drain", sb_q.size(), 0);

    // start held high: restart right after done; then stop+start together
    @(posedge CLOCK_50) #2;
    push_trace(40, 1'b1);
    push_trace(5, 1'b0);
    start = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(posedge CLOCK_50) #2;
      start = 1'b1;
      stop  = (c >= 45);
      if (c >= 46) begin
        #1;
        chk("stop_start_playing", int'(playing), 0);
        chk("stop_start_addr", int'(rom_addr), 0);
      end
    end
    @(posedge CLOCK_50) #2;
    start = 1'b0;
    stop  = 1'b0;
    chk("held_drain", sb_q.size(), 0);
    repeat (2) @(posedge CLOCK_50);

    // asynchronous reset in the middle of note 1
    @(posedge CLOCK_50) #2;
    push_trace(16, 1'b0);
    start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge CLOCK_50) #2;
      start = 1'b0;
    end
    @(posedge CLOCK_50) #3 resetn = 1'b0;
    #1 chk_idle("async_reset");
    chk("reset_drain", sb_q.size(), 0);
    @(posedge CLOCK_50) #2 resetn = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #3 chk("post_reset_playing", int'(playing), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
